// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width, counter sizing.
package bit_serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int count_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder processed LSB-first through one full_adder; done pulses WIDTH+1 edges after start.
// No backpressure: start is taken only in IDLE, and requests arriving while busy are dropped.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = count_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-2:0] shift_s_q, shift_s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] s_cat;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (shift_a_q[0]),
    .b    (shift_b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      shift_s_q <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      shift_s_q <= shift_s_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    shift_s_d = shift_s_q;
    carry_d   = carry_q;
    count_d   = count_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    // Partial result with the current sum bit on top; on the last bit this is the full sum.
    s_cat     = {fa_sum, shift_s_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          shift_a_d = a;
          shift_b_d = b;
          shift_s_d = '0;
          carry_d   = cin;
          count_d   = '0;
        end
      end
      RUN: begin
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        shift_s_d = s_cat[WIDTH-1:1];
        carry_d   = fa_cout;
        count_d   = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          count_d = '0;
          sum_d   = s_cat;
          cout_d  = fa_cout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: stimulus pushes expected results, a monitor checks each done.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           edge_n;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation, including its edge.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("done_sum", sum, e.s);
        chk("done_cout", cout, e.c);
        chk("done_edge", cyc, e.edge_n);
      end
    end
  end

  // Drive one start pulse; expectation edge is the acceptance edge plus W.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic [W-1:0] es, input logic ec, input bit push);
    exp_t e;
    @(negedge clk);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    if (push) begin
      e.s      = es;
      e.c      = ec;
      e.edge_n = cyc + 1 + W;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && busy === 1'b0) break;
      @(negedge clk);
    end
    chk("drain_outstanding", q.size(), 0);
  endtask

  initial begin
    int   bc;
    int   e0;
    exp_t e;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero operands; busy must span RUN plus DONE.
    issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    bc = 0;
    repeat (15) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc, 9);
    wait_idle(30);

    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_idle(30);

    issue(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1);
    wait_idle(30);
    issue(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_sum", sum, 8'h00);
    chk("hold_cout", cout, 1);
    wait_idle(30);
    chk("after_sum", sum, 8'h7E);

    // start and operand changes mid-run must be ignored.
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a     = 8'h11;
    b     = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    wait_idle(30);
    repeat (4) @(negedge clk);
    chk("ignored_start_sum", sum, 8'h46);
    chk("ignored_start_busy", busy, 0);

    // Abort at count==4; no done must follow.
    issue(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    repeat (12) @(negedge clk);
    issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);
    wait_idle(30);

    // start held high: back-to-back ops every W+2 cycles.
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    e0    = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.s      = 8'h02;
      e.c      = 1'b0;
      e.edge_n = e0 + W + k * (W + 2);
      q.push_back(e);
    end
    repeat (30) @(negedge clk);
    start = 1'b0;
    wait_idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
